mdu: RTL and testbench
======================

# mdu

Iterative multiply/divide unit implementing the RV32M operations. Sits directly downstream of the register file: it takes the two operands read on `rd0`/`rd1` plus the destination register index, computes over a fixed number of cycles, and presents a one-cycle write-back request (`we`/`wa`/`wd`) that drives the register file write port. While it works it holds `busy` so the control path stalls issue.

## Interface

Parameters:
- `XLEN`, 32: operand and result width. Only 32 is supported.
- `ITER`, 32: iteration count of the multi-cycle path. Must equal `XLEN`.

Ports:
- `clk`  in  1  clock, rising edge.
- `rstn`  in  1  reset. One clock; reset is synchronous and active-low.
- `start`  in  1  request. Sampled only in IDLE.
- `kill`  in  1  synchronous abort of any in-flight operation.
- `funct3`  in  3  operation select:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU;
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `src0`  in  XLEN  rs1 operand (register file `rd0`).
- `src1`  in  XLEN  rs2 operand (register file `rd1`).
- `rd_in`  in  5  destination register index.
- `busy`  out  1  high from the accept edge until the DONE cycle, inclusive.
- `done`  out  1  one-cycle completion strobe.
- `we`  out  1  register file write enable; equals `done`. Writes to x0 are filtered by the register file.
- `wa`  out  5  latched `rd_in`.
- `wd`  out  XLEN  result. Valid only while `done` is high; holds its value otherwise.

## Operation

States are IDLE, CALC and DONE.

- **IDLE.** When `start=1` and `kill=0` on an edge, the unit latches `funct3`, `src0`, `src1` and `rd_in`.
  - For a normal operation it moves to CALC and clears the counter.
  - For a division special case it moves directly to DONE with the result preloaded.
- **CALC.** Performs one iteration per cycle. The counter runs 0 to `ITER-1`. After iteration `ITER-1` the state moves to DONE.
- **DONE.** `done=we=1` for exactly one cycle. The next state is always IDLE, and `start` is not accepted during DONE.

Multiply:
- Operate on magnitudes with shift-add into a 2·XLEN accumulator.
- Signedness:
  - MUL and MULH: both operands signed.
  - MULHSU: `src0` signed, `src1` unsigned.
  - MULHU: both operands unsigned.
- Negate the 64-bit product when the operand signs differ.
- MUL returns the low word; the other three operations return the high word.

Divide:
- Restoring division on magnitudes, one quotient bit per iteration.
- DIV/REM signedness:
  - The quotient is negated when the operand signs differ.
  - The remainder takes the sign of the dividend.
- Special cases, which skip CALC:
  - `src1=0`: DIV/DIVU return 0xFFFFFFFF; REM/REMU return `src0`.
  - DIV with `src0=0x80000000` and `src1=0xFFFFFFFF`: returns 0x80000000. REM with the same operands returns 0.

Boundary conditions:
- `start` while busy: ignored; no queueing.
- `kill` in CALC or DONE: next state IDLE, no `done`/`we`. A kill in the DONE cycle cancels the write.
- `kill` and `start` together in IDLE: kill wins and nothing is accepted.
- `rstn=0` mid-operation: same effect as kill. Internal registers are cleared.
- Inputs may change freely after the accept edge; only the latched copies are used.

## Timing

- Reset values: `busy=0`, `done=0`, `we=0`, `wa=0`, `wd=0`; state IDLE; counter 0.
- Normal latency: with the accept edge at E0, CALC occupies the cycles after edges E0 through E31. DONE is the cycle after E32, so `done` is seen high at E33.
- Special-case latency: DONE is the cycle after E0, so `done` is seen high at E1.
- Back-to-back: the earliest next accept is the edge that ends DONE plus one, i.e. from IDLE. Throughput is one operation per 34 cycles.
- The write-back happens at the edge that closes the DONE cycle, in the register file's own write timing.

## Structure

- Package `mdu_pkg` holds:
  - `funct3` localparams `F3_MUL` through `F3_REMU`;
  - the state enum `IDLE`/`CALC`/`DONE`;
  - `XLEN`, `ITER` defaults;
  - the constants `DIV0_Q=32'hFFFFFFFF` and `INT_MIN=32'h80000000`.
- One sub-module, `mdu_divstep`: a combinational single restoring step. Inputs are the partial remainder, the next dividend bit and the divisor. Outputs are the new partial remainder and the quotient bit.
- The FSM, counter, sign handling and multiply datapath live in `mdu`.

## Test plan

1. MULH, `src0=0x80000000`, `src1=0x80000000`, `rd_in=5` → `done` at E33, `wa=5`, `wd=0x40000000`. Repeat with MUL → `wd=0x00000000`. Repeat with MULHU → `wd=0x40000000`.
2. DIV, `src0=0xFFFFFFF9` (−7), `src1=2` → `wd=0xFFFFFFFD`. REM with the same operands → `wd=0xFFFFFFFF`. DIVU with the same operands → `wd=0x7FFFFFFC`.
3. Division by zero:
   - DIVU `5/0` → `wd=0xFFFFFFFF` with `done` at E1.
   - REMU `5/0` → `wd=0x00000005`.
4. Overflow, `src0=0x80000000`, `src1=0xFFFFFFFF`: DIV → `0x80000000`; REM → `0`, both with `done` at E1.
5. Start a MUL, then assert `kill` at E10 → no `done`/`we`, `busy=0` after E10. A new `start` at E11 is accepted and completes at E44. A `start` pulsed at E5 during a busy operation is ignored.
6. Assert `rstn=0` at E20 of a DIV → all outputs 0 at the next edge. After release, MULHSU `0xFFFFFFFF` × `0xFFFFFFFF` → `wd=0xFFFFFFFF`.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the iterative RV32M multiply/divide unit.
//   - funct3 operation encodings (F3_MUL .. F3_REMU)
//   - FSM state enum (IDLE / CALC / DONE)
//   - default widths and the division special-case constants
package mdu_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int ITER_DEFAULT = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [31:0] DIV0_Q  = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mdu_divstep.sv
// mdu_divstep: one combinational restoring-division step.
//   rem      in   current partial remainder (always < divisor)
//   dbit     in   next dividend bit shifted in at the bottom
//   divisor  in   divisor magnitude
//   rem_next out  partial remainder after this step
//   qbit     out  quotient bit produced by this step
module mdu_divstep #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic            dbit,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic            qbit
);

  // The shifted remainder needs one extra bit: it can reach 2*divisor-1.
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  assign shifted  = {rem, dbit};
  assign diff     = shifted - {1'b0, divisor};
  assign qbit     = (shifted >= {1'b0, divisor});
  // Whichever branch is taken, the value is below the divisor and fits XLEN.
  assign rem_next = qbit ? diff[XLEN-1:0] : shifted[XLEN-1:0];

endmodule

// File: rtl/mdu.sv
// mdu: iterative RV32M multiply/divide unit feeding the register file port.
//   clk, rstn         clock (rising edge), synchronous active-low reset
//   start, kill       request (sampled in IDLE) and synchronous abort
//   funct3            operation select (MUL..REMU)
//   src0, src1        rs1 / rs2 operands
//   rd_in             destination register index
//   busy              high while an operation is accepted and not finished
//   done, we          one-cycle completion strobe / register file write enable
//   wa, wd            write-back address and result (wd holds between ops)
module mdu
  import mdu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int ITER = ITER_DEFAULT
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] src0,
  input  logic [XLEN-1:0] src1,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic            we,
  output logic [4:0]      wa,
  output logic [XLEN-1:0] wd
);

  localparam int CW = $clog2(ITER);

  state_t              state, state_next;
  logic [CW-1:0]       cnt;
  logic [2:0]          f3;
  logic                neg;
  logic [XLEN-1:0]     opb;
  // Shared accumulator: {hi, lo} is the product for multiply and
  // {remainder, dividend-shifting-into-quotient} for divide.
  logic [2*XLEN-1:0]   acc;

  // ---------------- operand decode at accept ----------------
  logic            accept, s0_signed, s1_signed, a_neg, b_neg, neg_in;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] special_res;

  assign accept    = (state == IDLE) && start && !kill;
  assign s0_signed = funct3[2] ? ~funct3[0] : (funct3 != F3_MULHU);
  assign s1_signed = funct3[2] ? ~funct3[0] : ~funct3[1];
  assign a_neg     = s0_signed & src0[XLEN-1];
  assign b_neg     = s1_signed & src1[XLEN-1];
  assign a_mag     = a_neg ? -src0 : src0;
  assign b_mag     = b_neg ? -src1 : src1;
  // The remainder follows the dividend's sign; everything else the XOR.
  assign neg_in    = (funct3[2] && funct3[1]) ? a_neg : (a_neg ^ b_neg);

  assign div_zero    = funct3[2] && (src1 == '0);
  assign div_ovf     = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                       (src0 == INT_MIN) && (src1 == '1);
  assign special     = div_zero || div_ovf;
  assign special_res = div_zero ? (funct3[1] ? src0 : DIV0_Q)
                                : (funct3[1] ? '0   : INT_MIN);

  // ---------------- one iteration per CALC cycle ----------------
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next, div_next, acc_next, prod;
  logic [XLEN-1:0]   rem_next, div_sel, mul_res, div_res, result;
  logic              qbit, last;

  assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
  assign mul_next = {mul_sum, acc[XLEN-1:1]};

  mdu_divstep #(.XLEN(XLEN)) u_divstep (
    .rem      (acc[2*XLEN-1:XLEN]),
    .dbit     (acc[XLEN-1]),
    .divisor  (opb),
    .rem_next (rem_next),
    .qbit     (qbit)
  );

  assign div_next = {rem_next, acc[XLEN-2:0], qbit};
  assign acc_next = f3[2] ? div_next : mul_next;
  assign last     = (cnt == CW'(ITER - 1));

  // Final sign fix-up is folded into the last iteration so the result is
  // registered on the edge that enters DONE.
  assign prod    = neg ? -acc_next : acc_next;
  assign mul_res = (f3 == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  assign div_sel = f3[1] ? acc_next[2*XLEN-1:XLEN] : acc_next[XLEN-1:0];
  assign div_res = neg ? -div_sel : div_sel;
  assign result  = f3[2] ? div_res : mul_res;

  // ---------------- FSM ----------------
  // NOTE: every signal written in always_comb gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = special ? DONE : CALC;
      CALC:    if (kill) state_next = IDLE;
               else if (last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: all datapath registers are reset too, so an aborted operation
  // leaves no stale operands or result visible after reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt <= '0;
      f3  <= '0;
      neg <= 1'b0;
      opb <= '0;
      acc <= '0;
      wa  <= '0;
      wd  <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          f3  <= funct3;
          wa  <= rd_in;
          neg <= neg_in;
          cnt <= '0;
          opb <= funct3[2] ? b_mag : a_mag;
          acc <= {{XLEN{1'b0}}, (funct3[2] ? a_mag : b_mag)};
          if (special) wd <= special_res;
        end
        CALC: if (!kill) begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
          if (last) wd <= result;
        end
        default: ;
      endcase
    end
  end

  // A kill (or reset) during DONE cancels the write in that same cycle.
  assign busy = (state != IDLE);
  assign done = (state == DONE) && !kill && rstn;
  assign we   = done;

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: scoreboard bench for mdu. The driver pushes the expected
// write-back (address, data, edge at which done is sampled) per request;
// an independent monitor pops and compares whenever done/we is seen.
module tb_mdu;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rstn, start, kill;
  logic [2:0]  funct3;
  logic [31:0] src0, src1;
  logic [4:0]  rd_in;
  logic        busy, done, we;
  logic [4:0]  wa;
  logic [31:0] wd;

  mdu #(.XLEN(32), .ITER(32)) dut (
    .clk(clk), .rstn(rstn), .start(start), .kill(kill), .funct3(funct3),
    .src0(src0), .src1(src1), .rd_in(rd_in), .busy(busy), .done(done),
    .we(we), .wa(wa), .wd(wd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [4:0]  wa;
    logic [31:0] wd;
    int          edge_n;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Drive one request on the next edge; lat is edges from accept to the
  // edge at which done is sampled (33 normal, 1 special case).
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] res, input int lat,
                       input string nm);
    exp_t e;
    @(negedge clk);
    funct3 = f; src0 = a; src1 = b; rd_in = rd; start = 1'b1;
    e.wa = rd; e.wd = res; e.edge_n = cyc + 1 + lat; e.name = nm;
    sb.push_back(e);
    @(posedge clk); #1;
    start  = 1'b0;
    src0   = $urandom;
    src1   = $urandom;
    funct3 = 3'($urandom);
    rd_in  = 5'($urandom);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_idle"}, 64'(busy), 64'd0);
    check({nm, "_drained"}, 64'(sb.size()), 64'd0);
  endtask

  // Monitor: compares every completion against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done || we) begin
        check("we_eq_done", 64'(we), 64'(done));
        if (sb.size() == 0) begin
          check("unexpected_done", 64'(done), 64'd0);
        end else begin
          e = sb.pop_front();
          check({e.name, "_wa"}, 64'(wa), 64'(e.wa));
          check({e.name, "_wd"}, 64'(wd), 64'(e.wd));
          check({e.name, "_edge"}, 64'(cyc + 1), 64'(e.edge_n));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog time_limit actual=expired required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    rstn = 1'b0; start = 1'b0; kill = 1'b0;
    funct3 = '0; src0 = '0; src1 = '0; rd_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {busy, done, we, wa, wd}, 64'd0);
    rstn = 1'b1;

    // Multiply of INT_MIN by itself in three signedness flavours.
    issue(F3_MULH,  32'h8000_0000, 32'h8000_0000, 5'd5, 32'h4000_0000, 33, "mulh_min");
    wait_idle("mulh_min");
    issue(F3_MUL,   32'h8000_0000, 32'h8000_0000, 5'd5, 32'h0000_0000, 33, "mul_min");
    wait_idle("mul_min");
    issue(F3_MULHU, 32'h8000_0000, 32'h8000_0000, 5'd5, 32'h4000_0000, 33, "mulhu_min");
    wait_idle("mulhu_min");
    check("wd_hold", 64'(wd), 64'h4000_0000);
    check("wa_hold", 64'(wa), 64'd5);
    issue(F3_MUL,   32'hFFFF_FFFD, 32'd5,         5'd8, 32'hFFFF_FFF1, 33, "mul_neg");
    wait_idle("mul_neg");

    // Signed / unsigned divide and remainder.
    issue(F3_DIV,  32'hFFFF_FFF9, 32'd2,         5'd6,  32'hFFFF_FFFD, 33, "div_m7");
    wait_idle("div_m7");
    issue(F3_REM,  32'hFFFF_FFF9, 32'd2,         5'd6,  32'hFFFF_FFFF, 33, "rem_m7");
    wait_idle("rem_m7");
    issue(F3_DIVU, 32'hFFFF_FFF9, 32'd2,         5'd6,  32'h7FFF_FFFC, 33, "divu_m7");
    wait_idle("divu_m7");
    issue(F3_DIV,  32'd100,       32'hFFFF_FFF9, 5'd10, 32'hFFFF_FFF2, 33, "div_100");
    wait_idle("div_100");
    issue(F3_REM,  32'd100,       32'hFFFF_FFF9, 5'd10, 32'h0000_0002, 33, "rem_100");
    wait_idle("rem_100");

    // Special cases bypass CALC.
    issue(F3_DIVU, 32'd5,         32'd0,         5'd11, 32'hFFFF_FFFF, 1, "divu_zero");
    wait_idle("divu_zero");
    issue(F3_REMU, 32'd5,         32'd0,         5'd11, 32'h0000_0005, 1, "remu_zero");
    wait_idle("remu_zero");
    issue(F3_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 1, "div_ovf");
    wait_idle("div_ovf");
    issue(F3_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h0000_0000, 1, "rem_ovf");
    wait_idle("rem_ovf");

    // Kill mid-CALC, with an ignored start while busy.
    @(negedge clk);
    funct3 = F3_MUL; src0 = 32'd3; src1 = 32'd4; rd_in = 5'd7; start = 1'b1;
    e0 = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc != e0 + 4) @(negedge clk);
    funct3 = F3_DIVU; src0 = 32'd9; src1 = 32'd0; rd_in = 5'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("ignored_start_busy", 64'(busy), 64'd1);
    check("ignored_start_wa", 64'(wa), 64'd7);
    while (cyc != e0 + 9) @(negedge clk);
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    check("kill_calc_busy", 64'(busy), 64'd0);
    issue(F3_MUL, 32'd3, 32'd4, 5'd7, 32'd12, 33, "mul_after_kill");
    wait_idle("mul_after_kill");

    // Kill during the DONE cycle cancels the write.
    @(negedge clk);
    funct3 = F3_DIVU; src0 = 32'd5; src1 = 32'd0; rd_in = 5'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; kill = 1'b1;
    @(negedge clk);
    check("kill_done_we", 64'(we), 64'd0);
    check("kill_done_busy", 64'(busy), 64'd1);
    @(posedge clk); #1;
    kill = 1'b0;
    check("kill_done_after", 64'(busy), 64'd0);

    // Kill together with start in IDLE: nothing accepted.
    @(negedge clk);
    funct3 = F3_MUL; src0 = 32'd1; src1 = 32'd1; rd_in = 5'd4; start = 1'b1; kill = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; kill = 1'b0;
    check("kill_start_idle", 64'(busy), 64'd0);

    // Reset in the middle of a divide.
    @(negedge clk);
    funct3 = F3_DIV; src0 = 32'd100; src1 = 32'd7; rd_in = 5'd12; start = 1'b1;
    e0 = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc != e0 + 19) @(negedge clk);
    rstn = 1'b0;
    @(posedge clk); #1;
    check("reset_mid_op", {busy, done, we, wa, wd}, 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    issue(F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'hFFFF_FFFF, 33, "mulhsu_m1");
    wait_idle("mulhsu_m1");

    repeat (3) @(negedge clk);
    check("final_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
